// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the CPU-side memory bus controller: FSM state encoding,
// request direction encoding and a small elaboration-time helper.
package mem_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Loadable down-counter that paces SRAM wait cycles; saturates at zero and
// flags zero combinationally so the FSM can leave RD/WR on the final edge.
module wait_counter #(
  parameter int W = 2
) (
  input  logic         iClk,
  input  logic         nRst,
  input  logic         iLoad,
  input  logic [W-1:0] iVal,
  output logic         oZero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iLoad)
      cnt_d = iVal;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign oZero = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus controller between the multicycle CPU memory port and a synchronous single-port
// SRAM: one request at a time, fixed wait cycles, one-cycle completion/error pulse.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iCpuEn,
  input  logic              iCpuRW,
  input  logic [31:0]       iCpuAddr,
  input  logic [31:0]       iCpuWData,
  output logic [31:0]       oCpuRData,
  output logic              oCpuReady,
  output logic              oCpuErr,
  output logic              oSramCe,
  output logic              oSramWe,
  output logic [ADDR_W-1:0] oSramAddr,
  output logic [31:0]       oSramWData,
  input  logic [31:0]       iSramRData
);

  localparam int          CNT_W      = $clog2(max_int(RD_LAT, WR_LAT) + 1);
  localparam logic [32:0] WORD_LIMIT = 33'(1) << ADDR_W;

  state_e            state_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              err_q;
  logic              ce_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       offset;
  logic [ADDR_W-1:0] word_addr;
  logic              req_bad;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;

  // BASE_ADDR is word aligned, so the offset's low bits carry the misalignment.
  // The range check compares the full 32-bit offset so huge addresses never wrap into range.
  assign offset    = iCpuAddr - BASE_ADDR;
  assign word_addr = offset[ADDR_W+1:2];
  assign req_bad   = (offset[1:0] != 2'b00) ||
                     (iCpuAddr < BASE_ADDR) ||
                     ({3'b000, offset[31:2]} >= WORD_LIMIT);

  assign cnt_load = (state_q == ST_IDLE) && iCpuEn && !req_bad;
  assign cnt_val  = (iCpuRW == MEM_WRITE) ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);

  wait_counter #(
    .W (CNT_W)
  ) u_wait (
    .iClk  (iClk),
    .nRst  (nRst),
    .iLoad (cnt_load),
    .iVal  (cnt_val),
    .oZero (cnt_zero)
  );

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iCpuEn) begin
            if (req_bad) begin
              state_q <= ST_ERR;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              ce_q   <= 1'b1;
              addr_q <= word_addr;
              if (iCpuRW == MEM_WRITE) begin
                state_q <= ST_WR;
                we_q    <= 1'b1;
                wdata_q <= iCpuWData;
              end else begin
                state_q <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (cnt_zero) begin
            rdata_q <= iSramRData;
            ce_q    <= 1'b0;
            addr_q  <= '0;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_WR: begin
          if (cnt_zero) begin
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE, ST_ERR: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oCpuRData  = rdata_q;
  assign oCpuReady  = ready_q;
  assign oCpuErr    = err_q;
  assign oSramCe    = ce_q;
  assign oSramWe    = we_q;
  assign oSramAddr  = addr_q;
  assign oSramWData = wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed scenarios plus randomized requests,
// expectations from a word-array reference model, checked by an independent monitor.
module tb_mem_bus_ctrl;

  localparam int          ADDR_W = 6;
  localparam int          NWORDS = 64;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  logic              iClk = 1'b0;
  logic              nRst = 1'b0;
  logic              iCpuEn = 1'b0;
  logic              iCpuRW = 1'b0;
  logic [31:0]       iCpuAddr = '0;
  logic [31:0]       iCpuWData = '0;
  logic [31:0]       oCpuRData;
  logic              oCpuReady;
  logic              oCpuErr;
  logic              oSramCe;
  logic              oSramWe;
  logic [ADDR_W-1:0] oSramAddr;
  logic [31:0]       oSramWData;
  logic [31:0]       iSramRData;

  mem_bus_ctrl #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT)
  ) dut (
    .iClk       (iClk),
    .nRst       (nRst),
    .iCpuEn     (iCpuEn),
    .iCpuRW     (iCpuRW),
    .iCpuAddr   (iCpuAddr),
    .iCpuWData  (iCpuWData),
    .oCpuRData  (oCpuRData),
    .oCpuReady  (oCpuReady),
    .oCpuErr    (oCpuErr),
    .oSramCe    (oSramCe),
    .oSramWe    (oSramWe),
    .oSramAddr  (oSramAddr),
    .oSramWData (oSramWData),
    .iSramRData (iSramRData)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  function automatic logic [31:0] init_pat(input int i);
    return (32'h9E37_79B9 * 32'(i)) ^ 32'h5A5A_5A5A;
  endfunction

  // SRAM model: read data only becomes valid once the address has been held RD_LAT-1 edges
  logic [31:0] sram_mem [NWORDS];
  bit          written  [NWORDS];
  int          rd_run;

  always @(posedge iClk) begin
    if (oSramCe && oSramWe) begin
      sram_mem[oSramAddr] <= oSramWData;
      written[oSramAddr]  <= 1'b1;
    end
  end

  always @(posedge iClk or negedge nRst) begin
    if (!nRst)                    rd_run <= 0;
    else if (oSramCe && !oSramWe) rd_run <= rd_run + 1;
    else                          rd_run <= 0;
  end

  assign iSramRData = (oSramCe && !oSramWe && rd_run >= RD_LAT - 1) ?
                      (written[oSramAddr] ? sram_mem[oSramAddr] : init_pat(int'(oSramAddr))) :
                      32'hBAD0_BAD0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    int                len;
  } sram_t;

  exp_t  exp_q[$];
  sram_t sq[$];

  logic [31:0] ref_mem [NWORDS];
  logic [31:0] last_rd;

  function automatic longint byte_off(input logic [31:0] a);
    return longint'({32'b0, a}) - longint'({32'b0, BASE});
  endfunction

  function automatic bit model_bad(input logic [31:0] a);
    longint off;
    off = byte_off(a);
    return (a % 4 != 0) || (off < 0) || (off / 4 >= NWORDS);
  endfunction

  // mode 0: drop request after accept; 1: keep iCpuEn high; 2: scramble fields and drop
  task automatic do_req(input logic rw, input logic [31:0] a, input logic [31:0] wd, input int mode);
    exp_t  e;
    sram_t s;
    int    idx;
    int    lat;
    bit    got;
    @(negedge iClk);
    iCpuEn    = 1'b1;
    iCpuRW    = rw;
    iCpuAddr  = a;
    iCpuWData = wd;
    @(posedge iClk);
    #1;
    lat = rw ? WR_LAT : RD_LAT;
    if (model_bad(a)) begin
      e.err   = 1'b1;
      e.rdata = last_rd;
      e.cyc   = cyc;
    end else begin
      idx = int'(byte_off(a) / 4);
      if (rw) ref_mem[idx] = wd;
      else    last_rd      = ref_mem[idx];
      e.err   = 1'b0;
      e.rdata = last_rd;
      e.cyc   = cyc + lat;
      s.addr  = ADDR_W'(idx);
      s.we    = rw;
      s.wdata = rw ? wd : 32'h0;
      s.len   = lat;
      sq.push_back(s);
    end
    exp_q.push_back(e);
    if (mode == 0) begin
      iCpuEn = 1'b0;
    end else if (mode == 2) begin
      iCpuEn    = 1'b0;
      iCpuRW    = ~rw;
      iCpuAddr  = a ^ 32'h0000_0024;
      iCpuWData = ~wd;
    end
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge iClk);
      if (oCpuReady) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ready_timeout", 32'(got), 32'h1);
    @(posedge iClk);
  endtask

  // Monitor: pairs every completion pulse and every SRAM burst with the oldest expectation
  exp_t              me;
  sram_t             ms;
  int                run = 0;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [31:0]       r_wd;

  always @(negedge iClk) begin
    if (!nRst) begin
      run = 0;
    end else begin
      if (oCpuReady) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'h1, 32'h0);
        end else begin
          me = exp_q.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(me.cyc));
          chk("err_flag", 32'(oCpuErr), 32'(me.err));
          chk("rdata", oCpuRData, me.rdata);
          chk("ce_in_done", 32'(oSramCe), 32'h0);
        end
      end else begin
        chk("err_without_ready", 32'(oCpuErr), 32'h0);
      end
      if (oSramCe) begin
        if (run == 0) begin
          r_addr = oSramAddr;
          r_we   = oSramWe;
          r_wd   = oSramWData;
        end else begin
          chk("sram_addr_stable", 32'(oSramAddr), 32'(r_addr));
          chk("sram_we_stable", 32'(oSramWe), 32'(r_we));
          chk("sram_wdata_stable", oSramWData, r_wd);
        end
        run++;
      end else begin
        chk("idle_sram_addr", 32'(oSramAddr), 32'h0);
        chk("idle_sram_wdata", oSramWData, 32'h0);
        chk("idle_sram_we", 32'(oSramWe), 32'h0);
        if (run > 0) begin
          if (sq.size() == 0) begin
            chk("unexpected_sram_access", 32'h1, 32'h0);
          end else begin
            ms = sq.pop_front();
            chk("sram_addr", 32'(r_addr), 32'(ms.addr));
            chk("sram_we", 32'(r_we), 32'(ms.we));
            chk("sram_wdata", r_wd, ms.wdata);
            chk("sram_len", 32'(run), 32'(ms.len));
          end
          run = 0;
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, oCpuRData, 32'h0);
    chk({tag, "_ready"}, 32'(oCpuReady), 32'h0);
    chk({tag, "_err"}, 32'(oCpuErr), 32'h0);
    chk({tag, "_ce"}, 32'(oSramCe), 32'h0);
    chk({tag, "_we"}, 32'(oSramWe), 32'h0);
    chk({tag, "_addr"}, 32'(oSramAddr), 32'h0);
    chk({tag, "_wdata"}, oSramWData, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    int          mode;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_pat(i);
    last_rd = 32'h0;

    #12;
    chk_all_zero("reset");
    @(negedge iClk);
    nRst = 1'b1;

    // Write then read back through the same word
    do_req(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b0, BASE + 32'h10, 32'h0, 0);

    // Asynchronous reset in the middle of a read aborts it silently
    @(negedge iClk);
    iCpuEn   = 1'b1;
    iCpuRW   = 1'b0;
    iCpuAddr = BASE + 32'h8;
    @(posedge iClk);
    #1;
    iCpuEn = 1'b0;
    @(posedge iClk);
    #3;
    nRst = 1'b0;
    #1;
    chk_all_zero("midrd_reset");
    exp_q.delete();
    sq.delete();
    last_rd = 32'h0;
    @(negedge iClk);
    @(negedge iClk);
    #2;
    nRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      chk("no_ready_after_reset", 32'(oCpuReady), 32'h0);
    end
    do_req(1'b0, BASE + 32'h10, 32'h0, 0);

    // Misaligned and out-of-range requests, plus the range edges
    do_req(1'b0, BASE + 32'h13, 32'h0, 0);
    do_req(1'b1, BASE + 32'h2, 32'h1111_2222, 0);
    do_req(1'b0, 32'h0000_0FFC, 32'h0, 0);
    do_req(1'b0, BASE + 32'(4 * NWORDS), 32'h0, 0);
    do_req(1'b1, 32'hFFFF_FFFC, 32'h3333_4444, 0);
    do_req(1'b0, BASE, 32'h0, 0);
    do_req(1'b1, BASE + 32'(4 * (NWORDS - 1)), 32'hCAFE_F00D, 0);
    do_req(1'b0, BASE + 32'(4 * (NWORDS - 1)), 32'h0, 0);

    // Request fields change after acceptance
    do_req(1'b1, BASE + 32'h20, 32'h1234_5678, 2);
    do_req(1'b0, BASE + 32'h20, 32'h0, 2);
    do_req(1'b0, BASE + 32'h24, 32'h0, 0);

    // Back-to-back with iCpuEn held through DONE/ERR
    do_req(1'b0, BASE + 32'h10, 32'h0, 1);
    do_req(1'b1, BASE + 32'h30, 32'hA5A5_0F0F, 1);
    do_req(1'b0, BASE + 32'h31, 32'h0, 1);
    do_req(1'b0, BASE + 32'h30, 32'h0, 0);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        6:       a = BASE + 32'($urandom_range(0, 4 * NWORDS - 1)) | 32'($urandom_range(1, 3));
        7:       a = 32'($urandom_range(0, int'(BASE) - 1)) & 32'hFFFF_FFFC;
        8:       a = BASE + 32'(4 * (NWORDS + $urandom_range(0, 5000)));
        9:       a = BASE + (($urandom_range(0, 1) == 1) ? 32'(4 * (NWORDS - 1)) : 32'h0);
        default: a = BASE + 32'(4 * $urandom_range(0, NWORDS - 1));
      endcase
      mode = $urandom_range(0, 2);
      do_req(1'($urandom_range(0, 1)), a, $urandom, mode);
      if (mode != 1) repeat ($urandom_range(0, 2)) @(posedge iClk);
    end

    @(negedge iClk);
    iCpuEn = 1'b0;
    repeat (6) @(negedge iClk);
    chk("pending_responses", 32'(exp_q.size()), 32'h0);
    chk("pending_sram_bursts", 32'(sq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
